writeback_regfile: RTL

//  Write-back stage plus architectural register file of the 5-stage RV32I pipeline.
//  - Consumes the M->W pipeline register outputs and selects the write-back result.
//  - Aligns and extends load data, writes rd, and serves the two decode-stage read ports.
//  - Exports the W-stage result for forwarding and counts retired instructions.

---
 rtl/writeback_regfile_if.sv | 37 +++
 rtl/writeback_regfile.sv | 91 +++++++++
 2 files changed

// File: rtl/writeback_regfile_if.sv
// W-stage bundle between the M->W pipeline register, decode and the write-back
// register file; master drives the W-stage inputs and decode read addresses.
interface writeback_regfile_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64,
  parameter int AW    = 5
);
  logic [XLEN-1:0]  iPCW;
  logic [XLEN-1:0]  iImmExtW;
  logic [XLEN-1:0]  iMemDataOutW;
  logic [XLEN-1:0]  iAluOutW;
  logic [AW-1:0]    iDestRegW;
  logic [2:0]       iResultSrcW;
  logic             iRegWriteEnW;
  logic [2:0]       iFunct3W;
  logic             iValidW;
  logic [AW-1:0]    iRs1D;
  logic [AW-1:0]    iRs2D;
  logic [XLEN-1:0]  oRd1D;
  logic [XLEN-1:0]  oRd2D;
  logic [XLEN-1:0]  oResultW;
  logic [CNT_W-1:0] oRetireCnt;

  modport master (
    output iPCW, iImmExtW, iMemDataOutW, iAluOutW,
    output iDestRegW, iResultSrcW, iRegWriteEnW,
    output iFunct3W, iValidW, iRs1D, iRs2D,
    input  oRd1D, oRd2D, oResultW, oRetireCnt
  );

  modport slave (
    input  iPCW, iImmExtW, iMemDataOutW, iAluOutW,
    input  iDestRegW, iResultSrcW, iRegWriteEnW,
    input  iFunct3W, iValidW, iRs1D, iRs2D,
    output oRd1D, oRd2D, oResultW, oRetireCnt
  );
endinterface

// File: rtl/writeback_regfile.sv
// RV32I write-back stage: result select, load alignment, register file
// with write-through read bypass, and retired-instruction counter.
module writeback_regfile #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int CNT_W    = 64
) (
  input logic                iClk,
  input logic                iRstN,
  writeback_regfile_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0]  regs [NUM_REGS];
  logic [CNT_W-1:0] retire_cnt;
  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  result;
  logic [1:0]       off;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic             wr_en;

  assign off     = bus.iAluOutW[1:0];
  assign ld_byte = bus.iMemDataOutW[8*off +: 8];
  assign ld_half = off[1] ? bus.iMemDataOutW[31:16]
                          : bus.iMemDataOutW[15:0];

  always_comb begin
    load_data = bus.iMemDataOutW;
    unique case (1'b1)
      (bus.iFunct3W == 3'b000):
        load_data = {{24{ld_byte[7]}}, ld_byte};
      (bus.iFunct3W == 3'b100):
        load_data = {24'd0, ld_byte};
      (bus.iFunct3W == 3'b001):
        load_data = {{16{ld_half[15]}}, ld_half};
      (bus.iFunct3W == 3'b101):
        load_data = {16'd0, ld_half};
      default:
        load_data = bus.iMemDataOutW;
    endcase
  end

  always_comb begin
    result = bus.iAluOutW;
    unique case (1'b1)
      (bus.iResultSrcW == 3'b001):
        result = load_data;
      (bus.iResultSrcW == 3'b010):
        result = bus.iPCW + 32'd4;
      (bus.iResultSrcW == 3'b011):
        result = bus.iImmExtW;
      (bus.iResultSrcW == 3'b100):
        result = bus.iPCW + bus.iImmExtW;
      default:
        result = bus.iAluOutW;
    endcase
  end

  assign wr_en = bus.iRegWriteEnW && (bus.iDestRegW != '0);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      retire_cnt <= '0;
    end else begin
      if (wr_en)
        regs[bus.iDestRegW] <= result;
      if (bus.iValidW)
        retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // x0 is never written, but the explicit guard keeps reads of it zero
  function automatic logic [XLEN-1:0] rd_port(
    input logic [AW-1:0] rs
  );
    if (wr_en && rs == bus.iDestRegW)
      return result;
    else if (rs == '0)
      return '0;
    else
      return regs[rs];
  endfunction

  assign bus.oRd1D      = rd_port(bus.iRs1D);
  assign bus.oRd2D      = rd_port(bus.iRs2D);
  assign bus.oResultW   = result;
  assign bus.oRetireCnt = retire_cnt;
endmodule
